// File: rtl/dec_mpp_recon.sv
// MPP reconstruction: dequantize four residual groups, add per-group
// midpoint, clamp to sample range, register out. Each group's midpoint
// tracks the rounded mean of its previous reconstructed block.

// Per-group lane: holds the midpoint and reconstructs 16 samples per block.
module dec_mpp_recon_lane #(
  parameter int BITDEPTH = 8,
  parameter int NSAMP    = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              blk_vld,
  input  logic [3:0]                        sh,
  input  logic [NSAMP-1:0][7:0]             qres,
  output logic [NSAMP-1:0][BITDEPTH-1:0]    recon
);
  // Signed working width covers residual << (BITDEPTH-1) plus midpoint.
  localparam int W  = BITDEPTH + 10;
  localparam int SW = BITDEPTH + 4;
  localparam logic [BITDEPTH-1:0] MID = BITDEPTH'(1 << (BITDEPTH - 1));

  logic [BITDEPTH-1:0]             mp;
  logic [NSAMP-1:0][BITDEPTH-1:0]  samp;
  logic [SW-1:0]                   sum;
  logic [BITDEPTH-1:0]             mean;

  for (genvar i = 0; i < NSAMP; i++) begin : g_samp
    logic signed [W-1:0] deq;
    logic signed [W-1:0] s_full;
    assign deq    = $signed({{(W-8){qres[i][7]}}, qres[i]}) <<< sh;
    assign s_full = $signed({{(W-BITDEPTH){1'b0}}, mp}) + deq;
    // Clamp the reconstructed sample to [0, 2^BITDEPTH-1].
    always_comb begin
      samp[i] = s_full[BITDEPTH-1:0];
      if (s_full[W-1])
        samp[i] = '0;
      else if (s_full > $signed({{(W-BITDEPTH){1'b0}}, {BITDEPTH{1'b1}}}))
        samp[i] = '1;
    end
  end

  // Sum of clamped samples; must settle in one cycle for back-to-back blocks.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NSAMP; k++)
      sum = sum + SW'(samp[k]);
  end

  // Rounded mean: (sum + 8) >> 4; cannot overflow since max sum is 2^SW-16.
  assign mean = BITDEPTH'((sum + SW'(8)) >> 4);

  // Register samples and next-block midpoint on each valid block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      recon <= '0;
      mp    <= MID;
    end else if (blk_vld) begin
      recon <= samp;
      mp    <= mean;
    end
  end
endmodule

module dec_mpp_recon #(
  parameter int BITDEPTH = 8,
  parameter int NSAMP    = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            blk_vld,
  input  logic [3:0]                      mpp_stepsize,
  input  logic [NSAMP-1:0][7:0]           mpp_qres_ssm0,
  input  logic [NSAMP-1:0][7:0]           mpp_qres_ssm1,
  input  logic [NSAMP-1:0][7:0]           mpp_qres_ssm2,
  input  logic [NSAMP-1:0][7:0]           mpp_qres_ssm3,
  output logic                            recon_vld,
  output logic [NSAMP-1:0][BITDEPTH-1:0]  recon_ssm0,
  output logic [NSAMP-1:0][BITDEPTH-1:0]  recon_ssm1,
  output logic [NSAMP-1:0][BITDEPTH-1:0]  recon_ssm2,
  output logic [NSAMP-1:0][BITDEPTH-1:0]  recon_ssm3
);
  localparam int NLANE = 4;
  localparam logic [3:0] SH_MAX = 4'(BITDEPTH - 1);

  logic [3:0]                                 sh;
  logic [NLANE-1:0][NSAMP-1:0][7:0]           qres_all;
  logic [NLANE-1:0][NSAMP-1:0][BITDEPTH-1:0]  recon_all;

  // Shifting past BITDEPTH-1 saturates anyway; cap it to bound the datapath.
  assign sh       = (mpp_stepsize > SH_MAX) ? SH_MAX : mpp_stepsize;
  assign qres_all = {mpp_qres_ssm3, mpp_qres_ssm2, mpp_qres_ssm1, mpp_qres_ssm0};

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    dec_mpp_recon_lane #(.BITDEPTH(BITDEPTH), .NSAMP(NSAMP)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .blk_vld (blk_vld),
      .sh      (sh),
      .qres    (qres_all[g]),
      .recon   (recon_all[g])
    );
  end

  assign recon_ssm0 = recon_all[0];
  assign recon_ssm1 = recon_all[1];
  assign recon_ssm2 = recon_all[2];
  assign recon_ssm3 = recon_all[3];

  // Output valid follows input valid with one cycle latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) recon_vld <= 1'b0;
    else       recon_vld <= blk_vld;
  end
endmodule

// File: tb/tb_dec_mpp_recon.sv
// Bench for dec_mpp_recon (BITDEPTH=8): directed scenarios plus random
// traffic, checked against an integer-arithmetic model of the decoder.
module tb_dec_mpp_recon;
  localparam int BD = 8;
  localparam int NS = 16;
  localparam int MAXV = (1 << BD) - 1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic blk_vld = 1'b0;
  logic [3:0] mpp_stepsize = '0;
  logic [NS-1:0][7:0] mpp_qres_ssm0 = '0, mpp_qres_ssm1 = '0,
                      mpp_qres_ssm2 = '0, mpp_qres_ssm3 = '0;
  logic recon_vld;
  logic [NS-1:0][BD-1:0] recon_ssm0, recon_ssm1, recon_ssm2, recon_ssm3;

  dec_mpp_recon #(.BITDEPTH(BD), .NSAMP(NS)) dut (
    .clk(clk), .rstn(rstn), .blk_vld(blk_vld), .mpp_stepsize(mpp_stepsize),
    .mpp_qres_ssm0(mpp_qres_ssm0), .mpp_qres_ssm1(mpp_qres_ssm1),
    .mpp_qres_ssm2(mpp_qres_ssm2), .mpp_qres_ssm3(mpp_qres_ssm3),
    .recon_vld(recon_vld), .recon_ssm0(recon_ssm0), .recon_ssm1(recon_ssm1),
    .recon_ssm2(recon_ssm2), .recon_ssm3(recon_ssm3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  byte q [4][NS];          // residuals to drive
  int  mp [4];             // model midpoints
  int  exp_r [4][NS];      // model outputs
  int  exp_v;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_out(input int g, input int i);
    case (g)
      0: return int'(recon_ssm0[i]);
      1: return int'(recon_ssm1[i]);
      2: return int'(recon_ssm2[i]);
      default: return int'(recon_ssm3[i]);
    endcase
  endfunction

  task automatic model_reset();
    exp_v = 0;
    for (int g = 0; g < 4; g++) begin
      mp[g] = 1 << (BD - 1);
      for (int i = 0; i < NS; i++) exp_r[g][i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_vld"}, int'(recon_vld), exp_v);
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < NS; i++)
        chk($sformatf("%s_g%0d_s%0d", tag, g, i), dut_out(g, i), exp_r[g][i]);
  endtask

  // One clock: drive inputs, advance the model, check #1 after the edge.
  task automatic step(input bit v, input int st, input string tag);
    int sh, s, sum;
    blk_vld = v;
    mpp_stepsize = 4'(st);
    for (int i = 0; i < NS; i++) begin
      mpp_qres_ssm0[i] = q[0][i]; mpp_qres_ssm1[i] = q[1][i];
      mpp_qres_ssm2[i] = q[2][i]; mpp_qres_ssm3[i] = q[3][i];
    end
    if (!rstn) model_reset();
    else begin
      exp_v = v;
      if (v) begin
        sh = (st > BD - 1) ? BD - 1 : st;
        for (int g = 0; g < 4; g++) begin
          sum = 0;
          for (int i = 0; i < NS; i++) begin
            s = mp[g] + int'(q[g][i]) * (1 << sh);
            if (s < 0) s = 0;
            if (s > MAXV) s = MAXV;
            exp_r[g][i] = s;
            sum += s;
          end
          mp[g] = (sum + 8) / 16;
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic fill(input int g, input int val);
    for (int i = 0; i < NS; i++) q[g][i] = byte'(val);
  endtask

  task automatic fill_all(input int val);
    for (int g = 0; g < 4; g++) fill(g, val);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all("rst");
    @(posedge clk); #3 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    // 1. reset state, then zero block -> midpoint 128
    do_reset();
    fill_all(0);
    step(1, 0, "s1_zero");
    chk("s1_lit", int'(recon_ssm3[15]), 128);
    // 2. positive dequant
    fill_all(3);
    step(1, 2, "s2_pos");
    chk("s2_lit", int'(recon_ssm0[0]), 140);
    fill_all(0);
    step(1, 0, "s2_mp");
    chk("s2_mp_lit", int'(recon_ssm2[7]), 140);
    // 3. clamp low, clamp high with shift saturation, then hold mids
    fill_all(-128);
    step(1, 3, "s3_lo");
    chk("s3_lo_lit", int'(recon_ssm1[3]), 0);
    fill_all(0); fill(1, 127);
    step(1, 15, "s3_hi");
    chk("s3_hi_lit", int'(recon_ssm1[3]), 255);
    fill_all(0);
    step(1, 0, "s3_mp");
    chk("s3_mp0_lit", int'(recon_ssm0[0]), 0);
    chk("s3_mp1_lit", int'(recon_ssm1[0]), 255);
    // 4. mean rounding on lane 0
    do_reset();
    fill_all(0);
    for (int i = 0; i < 8; i++) q[0][i] = 8'sd1;
    step(1, 0, "s4_r8");
    fill_all(0);
    step(1, 0, "s4_r8_mp");
    chk("s4_mean129", int'(recon_ssm0[0]), 129);
    chk("s4_lane1", int'(recon_ssm1[0]), 128);
    do_reset();
    fill_all(0);
    for (int i = 0; i < 7; i++) q[0][i] = 8'sd1;
    step(1, 0, "s4_r7");
    fill_all(0);
    step(1, 0, "s4_r7_mp");
    chk("s4_mean128", int'(recon_ssm0[0]), 128);
    // 5. back-to-back then gap
    do_reset();
    fill_all(10);
    step(1, 0, "s5_b0"); chk("s5_138", int'(recon_ssm2[5]), 138);
    step(1, 0, "s5_b1"); chk("s5_148", int'(recon_ssm2[5]), 148);
    step(1, 0, "s5_b2"); chk("s5_158", int'(recon_ssm2[5]), 158);
    fill_all(-50);
    step(0, 7, "s5_gap0");
    step(0, 7, "s5_gap1");
    chk("s5_hold", int'(recon_ssm2[5]), 158);
    // 6. reset mid-stream during continuous valid
    fill_all(5);
    step(1, 1, "s6_pre");
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all("s6_async");
    step(1, 1, "s6_inrst");
    #3 rstn = 1'b1;
    fill_all(0);
    step(1, 0, "s6_post");
    chk("s6_128", int'(recon_ssm0[9]), 128);
    // random traffic
    for (int n = 0; n < 300; n++) begin
      int mode = $urandom_range(0, 3);
      for (int g = 0; g < 4; g++)
        for (int i = 0; i < NS; i++)
          case (mode)
            0: q[g][i] = byte'($urandom_range(0, 255));
            1, 2: q[g][i] = byte'(int'($urandom_range(0, 8)) - 4);
            default: q[g][i] = 8'sd0;
          endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $sformatf("rnd%0d", n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
